lab4_serial_adder_ctrl: RTL and testbench

//  Push-button responder for the lab4 adder board interface. Samples the active-low LoadB/Run

---
 rtl/lab4_serial_adder_ctrl.sv | 128 ++++++++++++
 tb/tb_lab4_serial_adder_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lab4_serial_adder_ctrl.sv
// Button/switch front end for the lab4 adder board with a bit-serial adder behind it:
// one sum bit per clock, result registered into Sum/CO only when the add completes.
module lab4_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             Busy,
  output logic             Done,
  output logic [1:0]       DbgState
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, WAIT_REL} state_t;

  state_t           state_q, state_d;
  logic             lb_q, lb_d, run_q, run_d;
  logic [WIDTH-1:0] a_val_q, a_val_d, b_val_q, b_val_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d, done_q, done_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, psum_q, psum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             lb_press, run_press, s_bit;

  always_comb begin
    state_d  = state_q;
    lb_d     = LoadB;
    run_d    = Run;
    a_val_d  = a_val_q;
    b_val_d  = b_val_q;
    sum_d    = sum_q;
    co_d     = co_q;
    done_d   = 1'b0;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    psum_d   = psum_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    // A press is a high-to-low step between the previous sample and this edge's input.
    lb_press  = lb_q & ~LoadB;
    run_press = run_q & ~Run;
    s_bit     = a_sh_q[0] ^ b_sh_q[0] ^ c_q;

    case (state_q)
      IDLE: begin
        if (lb_press) b_val_d = SW;
        if (run_press) begin
          a_val_d = SW;
          a_sh_d  = SW;
          b_sh_d  = lb_press ? SW : b_val_q;
          c_d     = 1'b0;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        c_d    = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        psum_d = {s_bit, psum_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        sum_d   = psum_q;
        co_d    = c_q;
        done_d  = 1'b1;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (lb_press) b_val_d = SW;
        if (run_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      lb_q    <= 1'b1;
      run_q   <= 1'b1;
      a_val_q <= '0;
      b_val_q <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      done_q  <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      psum_q  <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      lb_q    <= lb_d;
      run_q   <= run_d;
      a_val_q <= a_val_d;
      b_val_q <= b_val_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      done_q  <= done_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
    end
  end

  assign Aval     = a_val_q;
  assign Bval     = b_val_q;
  assign Sum      = sum_q;
  assign CO       = co_q;
  assign Done     = done_q;
  assign Busy     = (state_q == SHIFT);
  assign DbgState = state_q;

endmodule

// File: tb/tb_lab4_serial_adder_ctrl.sv
// Directed bench for lab4_serial_adder_ctrl: reset, normal adds, carry-out cases,
// held/ignored buttons, reset abort and simultaneous LoadB/Run.
module tb_lab4_serial_adder_ctrl;

  localparam int W = 16;
  localparam logic [1:0] ST_WAIT_REL = 2'd3;

  logic         Clk = 1'b0;
  logic         Reset, LoadB, Run;
  logic [W-1:0] SW;
  logic [W-1:0] Aval, Bval, Sum;
  logic         CO, Busy, Done;
  logic [1:0]   DbgState;

  int total = 0;
  int bad   = 0;
  int busy_n, done_n, done_at;

  lab4_serial_adder_ctrl #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .SW(SW),
    .Aval(Aval), .Bval(Bval), .Sum(Sum), .CO(CO), .Busy(Busy), .Done(Done),
    .DbgState(DbgState)
  );

  always #5 Clk = ~Clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load_b(input logic [W-1:0] v);
    SW = v; LoadB = 1'b0;
    step(1);
    LoadB = 1'b1;
    step(1);
  endtask

  // Press Run (edge N), then watch ncyc further edges with Run still held low.
  // Optional LoadB press at iteration lb_at and reset pulse at iteration rst_at (0 = none).
  task automatic run_watch(input logic [W-1:0] a, input int ncyc, input int lb_at,
                           input logic [W-1:0] lb_sw, input int rst_at);
    SW = a; Run = 1'b0;
    step(1);
    busy_n = int'(Busy); done_n = int'(Done); done_at = 0;
    for (int i = 1; i <= ncyc; i++) begin
      if (lb_at != 0 && i == lb_at)     begin SW = lb_sw; LoadB = 1'b0; end
      if (lb_at != 0 && i == lb_at + 1) LoadB = 1'b1;
      if (rst_at != 0 && i == rst_at)     begin Reset = 1'b0; Run = 1'b1; end
      if (rst_at != 0 && i == rst_at + 1) Reset = 1'b1;
      step(1);
      busy_n += int'(Busy);
      done_n += int'(Done);
      if (Done && done_at == 0) done_at = i;
    end
  endtask

  task automatic release_run();
    Run = 1'b1;
    step(3);
  endtask

  initial begin
    Reset = 1'b0; LoadB = 1'b1; Run = 1'b1; SW = 16'hFFFF;
    step(2);
    check("rst_aval", Aval, 0);
    check("rst_bval", Bval, 0);
    check("rst_sum",  Sum,  0);
    check("rst_co",   CO,   0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    Reset = 1'b1;
    step(1);

    // 0x0001 + 0x000D
    load_b(16'h000D);
    check("t2_bval", Bval, 16'h000D);
    run_watch(16'h0001, 30, 0, 16'h0, 0);
    check("t2_aval",    Aval,    16'h0001);
    check("t2_busy_n",  busy_n,  16);
    check("t2_done_n",  done_n,  1);
    check("t2_done_at", done_at, 17);
    check("t2_sum",     Sum,     16'h000E);
    check("t2_co",      CO,      0);
    release_run();
    check("t2_sum_hold", Sum, 16'h000E);

    load_b(16'hFFFF);
    run_watch(16'h0001, 20, 0, 16'h0, 0);
    check("t3a_sum", Sum, 16'h0000);
    check("t3a_co",  CO,  1);
    release_run();
    load_b(16'h8000);
    run_watch(16'h8000, 20, 0, 16'h0, 0);
    check("t3b_sum", Sum, 16'h0000);
    check("t3b_co",  CO,  1);
    release_run();

    // Run held 60 cycles, LoadB pressed mid-add with SW=1234 (ignored), A=0005 stays.
    run_watch(16'h0005, 60, 5, 16'h1234, 0);
    check("t4_done_n", done_n, 1);
    check("t4_bval",   Bval,   16'h8000);
    check("t4_sum",    Sum,    16'h8005);
    check("t4_co",     CO,     0);
    check("t4_state",  DbgState, ST_WAIT_REL);
    load_b(16'h1234);
    check("t4_bval_after", Bval, 16'h1234);
    release_run();

    // Reset at the 8th SHIFT edge aborts the add.
    run_watch(16'h0001, 30, 0, 16'h0, 8);
    check("t5_done_n", done_n, 0);
    check("t5_busy",   Busy,   0);
    check("t5_sum",    Sum,    0);
    check("t5_bval",   Bval,   0);
    release_run();
    load_b(16'h0002);
    run_watch(16'h0003, 20, 0, 16'h0, 0);
    check("t5_done_at", done_at, 17);
    check("t5_sum2",    Sum,     16'h0005);
    check("t5_co2",     CO,      0);
    release_run();

    // LoadB and Run fall on the same edge.
    SW = 16'h8001; LoadB = 1'b0;
    run_watch(16'h8001, 20, 0, 16'h0, 0);
    LoadB = 1'b1;
    check("t6_aval",    Aval,    16'h8001);
    check("t6_bval",    Bval,    16'h8001);
    check("t6_sum",     Sum,     16'h0002);
    check("t6_co",      CO,      1);
    check("t6_done_at", done_at, 17);
    release_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
